// File: rtl/median_filter_subsystem.sv
// rtl/median_filter_subsystem.sv - 3x3 median filter engine: coordinator, window filter and shared word memory
// The coordinator walks the 7x7 output grid; the filter reads one window, writes its median and hands back.

module mfs_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 8,
  parameter int DATA_DEPTH = 130
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rw,
  input  logic [BUS_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] mem_odata,
  output logic                  mem_drdy,
  input  logic [BUS_WIDTH-1:0]  host_addr,
  output logic [DATA_WIDTH-1:0] host_rdata
);
  localparam logic [BUS_WIDTH-1:0] DEPTH = BUS_WIDTH'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  // Storage has no reset so an aborted run keeps whatever it already wrote.
  always_ff @(posedge clk) begin
    if (rw == 2'b10 && addr < DEPTH) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_odata <= '0;
      mem_drdy  <= 1'b0;
    end else begin
      mem_drdy <= (rw == 2'b01);
      if (rw == 2'b01) mem_odata <= (addr < DEPTH) ? mem[addr] : '0;
    end
  end

  assign host_rdata = (host_addr < DEPTH) ? mem[host_addr] : '0;
endmodule

module mfs_coordinator #(
  parameter int BUS_WIDTH = 8,
  parameter int OUT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt,
  input  logic                 filt_rdy,
  output logic                 filt_en,
  output logic                 sel,
  output logic                 busy,
  output logic                 dne,
  output logic [BUS_WIDTH-1:0] srow,
  output logic [BUS_WIDTH-1:0] scol
);
  localparam logic [BUS_WIDTH-1:0] LAST = BUS_WIDTH'(OUT_WIDTH - 1);

  typedef enum logic [2:0] {C_IDLE, C_ENABLE, C_WAIT, C_ADVANCE, C_FINISH} cstate_t;
  cstate_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= C_IDLE;
      filt_en <= 1'b0;
      sel     <= 1'b0;
      busy    <= 1'b0;
      dne     <= 1'b0;
      srow    <= '0;
      scol    <= '0;
    end else begin
      case (state)
        C_IDLE: begin
          if (strt) begin
            dne     <= 1'b0;
            busy    <= 1'b1;
            srow    <= '0;
            scol    <= '0;
            filt_en <= 1'b1;
            sel     <= 1'b1;
            state   <= C_ENABLE;
          end
        end
        C_ENABLE: begin
          filt_en <= 1'b0;
          state   <= C_WAIT;
        end
        C_WAIT: begin
          if (filt_rdy) state <= C_ADVANCE;
        end
        C_ADVANCE: begin
          if (scol == LAST) begin
            scol <= '0;
            if (srow == LAST) begin
              srow  <= '0;
              state <= C_FINISH;
            end else begin
              srow    <= srow + 1'b1;
              filt_en <= 1'b1;
              state   <= C_ENABLE;
            end
          end else begin
            scol    <= scol + 1'b1;
            filt_en <= 1'b1;
            state   <= C_ENABLE;
          end
        end
        C_FINISH: begin
          dne   <= 1'b1;
          busy  <= 1'b0;
          sel   <= 1'b0;
          state <= C_IDLE;
        end
        default: state <= C_IDLE;
      endcase
    end
  end
endmodule

module mfs_filter #(
  parameter int DATA_WIDTH  = 16,
  parameter int BUS_WIDTH   = 8,
  parameter int WINDOW_SIZE = 3,
  parameter int IMG_WIDTH   = 9,
  parameter int OUT_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  filt_en,
  input  logic [BUS_WIDTH-1:0]  srow,
  input  logic [BUS_WIDTH-1:0]  scol,
  input  logic [DATA_WIDTH-1:0] mem_odata,
  input  logic                  mem_drdy,
  output logic                  filt_rdy,
  output logic [1:0]            rw,
  output logic [BUS_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0] wdata
);
  localparam int WIN_N = WINDOW_SIZE * WINDOW_SIZE;
  localparam logic [1:0] K_LAST = 2'(WINDOW_SIZE - 1);
  localparam logic [3:0] MID = 4'(WIN_N / 2);
  localparam logic [BUS_WIDTH-1:0] IMG_W = BUS_WIDTH'(IMG_WIDTH);
  localparam logic [BUS_WIDTH-1:0] OUT_W = BUS_WIDTH'(OUT_WIDTH);
  localparam logic [BUS_WIDTH-1:0] OUT_BASE = BUS_WIDTH'(IMG_WIDTH * IMG_WIDTH);

  typedef enum logic [2:0] {F_IDLE, F_READ, F_CAPTURE, F_MEDIAN, F_WRITE, F_READY} fstate_t;
  fstate_t state;

  logic [1:0]            kr, kc;
  logic [3:0]            k;
  logic [DATA_WIDTH-1:0] win [WIN_N];
  logic [DATA_WIDTH-1:0] med;
  logic [3:0]            rank;

  function automatic logic [BUS_WIDTH-1:0] pix_addr(input logic [BUS_WIDTH-1:0] r,
                                                    input logic [BUS_WIDTH-1:0] c,
                                                    input logic [1:0] dr,
                                                    input logic [1:0] dc);
    return (r + BUS_WIDTH'(dr)) * IMG_W + c + BUS_WIDTH'(dc);
  endfunction

  // Rank each sample by strict-less count, index breaking ties, so duplicates get distinct ranks.
  always_comb begin
    med  = '0;
    rank = '0;
    for (int i = 0; i < WIN_N; i++) begin
      rank = '0;
      for (int j = 0; j < WIN_N; j++) begin
        if (win[j] < win[i] || (win[j] == win[i] && j < i)) rank = rank + 4'd1;
      end
      if (rank == MID) med = win[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= F_IDLE;
      filt_rdy <= 1'b0;
      rw       <= 2'b00;
      addr     <= '0;
      wdata    <= '0;
      kr       <= '0;
      kc       <= '0;
      k        <= '0;
      for (int i = 0; i < WIN_N; i++) win[i] <= '0;
    end else begin
      case (state)
        F_IDLE: begin
          if (filt_en) begin
            kr    <= '0;
            kc    <= '0;
            k     <= '0;
            rw    <= 2'b01;
            addr  <= pix_addr(srow, scol, 2'd0, 2'd0);
            state <= F_READ;
          end
        end
        F_READ: begin
          rw    <= 2'b00;
          state <= F_CAPTURE;
        end
        F_CAPTURE: begin
          if (mem_drdy) begin
            win[k] <= mem_odata;
            if (kr == K_LAST && kc == K_LAST) begin
              state <= F_MEDIAN;
            end else begin
              k     <= k + 4'd1;
              rw    <= 2'b01;
              state <= F_READ;
              if (kc == K_LAST) begin
                kc   <= '0;
                kr   <= kr + 2'd1;
                addr <= pix_addr(srow, scol, kr + 2'd1, 2'd0);
              end else begin
                kc   <= kc + 2'd1;
                addr <= pix_addr(srow, scol, kr, kc + 2'd1);
              end
            end
          end
        end
        F_MEDIAN: begin
          wdata <= med;
          addr  <= OUT_BASE + srow * OUT_W + scol;
          rw    <= 2'b10;
          state <= F_WRITE;
        end
        F_WRITE: begin
          rw       <= 2'b00;
          filt_rdy <= 1'b1;
          state    <= F_READY;
        end
        F_READY: begin
          filt_rdy <= 1'b0;
          state    <= F_IDLE;
        end
        default: state <= F_IDLE;
      endcase
    end
  end
endmodule

module median_filter_subsystem #(
  parameter int DATA_WIDTH  = 16,
  parameter int BUS_WIDTH   = 8,
  parameter int WINDOW_SIZE = 3,
  parameter int IMG_WIDTH   = 9,
  parameter int OUT_WIDTH   = 7,
  parameter int DATA_DEPTH  = 130
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strt,
  input  logic                  host_we,
  input  logic [BUS_WIDTH-1:0]  host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  busy,
  output logic                  dne
);
  logic                  filt_en, filt_rdy, sel, mem_drdy;
  logic [BUS_WIDTH-1:0]  srow, scol, filt_addr, bus_addr;
  logic [1:0]            filt_rw, coord_rw, bus_rw;
  logic [DATA_WIDTH-1:0] filt_wdata, bus_wdata, mem_odata;

  // The coordinator side of the bus carries host writes, gated off for the whole run.
  assign coord_rw  = (host_we && !busy) ? 2'b10 : 2'b00;
  assign bus_rw    = sel ? filt_rw    : coord_rw;
  assign bus_addr  = sel ? filt_addr  : host_addr;
  assign bus_wdata = sel ? filt_wdata : host_wdata;

  mfs_coordinator #(.BUS_WIDTH(BUS_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_coord (
    .clk(clk), .rst(rst), .strt(strt), .filt_rdy(filt_rdy), .filt_en(filt_en),
    .sel(sel), .busy(busy), .dne(dne), .srow(srow), .scol(scol)
  );

  mfs_filter #(
    .DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .WINDOW_SIZE(WINDOW_SIZE),
    .IMG_WIDTH(IMG_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) u_filt (
    .clk(clk), .rst(rst), .filt_en(filt_en), .srow(srow), .scol(scol),
    .mem_odata(mem_odata), .mem_drdy(mem_drdy), .filt_rdy(filt_rdy),
    .rw(filt_rw), .addr(filt_addr), .wdata(filt_wdata)
  );

  mfs_memory #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .DATA_DEPTH(DATA_DEPTH)) u_mem (
    .clk(clk), .rst(rst), .rw(bus_rw), .addr(bus_addr), .wdata(bus_wdata),
    .mem_odata(mem_odata), .mem_drdy(mem_drdy), .host_addr(host_addr), .host_rdata(host_rdata)
  );
endmodule

// File: tb/tb_median_filter_subsystem.sv
// tb/tb_median_filter_subsystem.sv - randomized bench for median_filter_subsystem against a behavioural model
module tb_median_filter_subsystem;
  localparam int NPIX = 81;
  localparam int NMEM = 130;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        strt = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = 8'd0;
  logic [15:0] host_wdata = 16'd0;
  logic [15:0] host_rdata;
  logic        busy, dne;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [15:0] mm  [NMEM];
  logic [15:0] img [NPIX];
  bit m_busy = 1'b0;
  bit m_dne  = 1'b0;
  int cnt    = 0;

  always #5 clk = ~clk;

  median_filter_subsystem dut (
    .clk(clk), .rst(rst), .strt(strt), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .busy(busy), .dne(dne)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] win_median(input int r, input int c);
    logic [15:0] s [9];
    logic [15:0] t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s[i*3+j] = mm[(r+i)*9 + c + j];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[4];
  endfunction

  // Model: edge count since start decides which output word lands when, and when dne rises.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_dne  = 1'b0;
      cnt    = 0;
    end else if (m_busy) begin
      cnt++;
      if (cnt % 23 == 21 && cnt / 23 < 49) mm[81 + cnt/23] = win_median((cnt/23) / 7, (cnt/23) % 7);
      if (cnt == 1128) begin m_busy = 1'b0; m_dne = 1'b1; end
    end else begin
      if (host_we && host_addr < 8'd130) mm[host_addr] = host_wdata;
      if (strt) begin m_busy = 1'b1; m_dne = 1'b0; cnt = 0; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("dne", {31'd0, dne}, {31'd0, m_dne});
      check($sformatf("rdata@%0d", host_addr), {16'd0, host_rdata}, {16'd0, mm[host_addr]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_all();
    for (int a = 0; a < NMEM; a++) begin
      host_we    = 1'b1;
      host_addr  = 8'(a);
      host_wdata = (a < NPIX) ? img[a] : 16'h0000;
      tick();
    end
    host_we = 1'b0;
  endtask

  task automatic readback();
    for (int a = 0; a < NMEM; a++) begin
      host_addr = 8'(a);
      tick();
    end
  endtask

  task automatic peek(input int a, output logic [15:0] v);
    host_addr = 8'(a);
    #1;
    v = host_rdata;
  endtask

  task automatic peek_check(input string name, input int a, input logic [15:0] exp);
    logic [15:0] v;
    peek(a, v);
    check(name, {16'd0, v}, {16'd0, exp});
  endtask

  task automatic run_img(input string name, input int hold, input int poke_at, input int abort_at);
    int n;
    bit seen;
    strt = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    strt = 1'b0;
    n    = hold - 1;
    seen = 1'b0;
    while (n < 1200 && !seen) begin
      tick();
      n++;
      if (n == poke_at) begin
        strt = 1'b1; host_we = 1'b1; host_addr = 8'd10; host_wdata = 16'hDEAD;
      end
      if (n == poke_at + 1) begin
        strt = 1'b0; host_we = 1'b0;
      end
      if (n == abort_at) begin
        rst = 1'b0;
        #1;
        check({name, " abort busy"}, {31'd0, busy}, 32'd0);
        check({name, " abort dne"}, {31'd0, dne}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        return;
      end
      if (dne) seen = 1'b1;
    end
    check({name, " dne cycle"}, n, 32'd1128);
  endtask

  initial begin
    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset dne", {31'd0, dne}, 32'd0);
    rst = 1'b1;
    tick();

    for (int a = 0; a < NPIX; a++) img[a] = 16'h0005;
    load_all();
    chk_en = 1'b1;
    run_img("const", 1, -1, -1);
    readback();
    peek_check("const out00", 81, 16'h0005);
    peek_check("const out33", 105, 16'h0005);
    peek_check("const out66", 129, 16'h0005);

    for (int a = 0; a < NPIX; a++) img[a] = 16'(a);
    load_all();
    run_img("ramp", 1, -1, -1);
    readback();
    peek_check("ramp out00", 81, 16'h000A);
    peek_check("ramp out66", 129, 16'h0046);

    for (int a = 0; a < NPIX; a++) img[a] = 16'h0100;
    img[40] = 16'hFFFF;
    img[0]  = 16'h0000;
    load_all();
    run_img("impulse", 1, -1, -1);
    readback();
    peek_check("impulse out00", 81, 16'h0100);
    peek_check("impulse out33", 105, 16'h0100);
    peek_check("impulse out66", 129, 16'h0100);

    for (int a = 0; a < NPIX; a++) img[a] = 16'h0000;
    img[0] = 16'd1; img[1] = 16'd1; img[2] = 16'd1;
    img[9] = 16'd1; img[10] = 16'd2; img[11] = 16'd9;
    img[18] = 16'd9; img[19] = 16'd9; img[20] = 16'd9;
    load_all();
    run_img("dup", 1, -1, -1);
    readback();
    peek_check("dup out00", 81, 16'h0002);
    peek_check("dup out01", 82, 16'h0001);

    for (int a = 0; a < NPIX; a++) img[a] = 16'($urandom_range(0, 3));
    load_all();
    run_img("rand small", 1, -1, -1);
    readback();

    for (int a = 0; a < NPIX; a++) img[a] = 16'($urandom);
    load_all();
    run_img("rand full", 1, -1, -1);
    readback();

    for (int a = 0; a < NPIX; a++) img[a] = 16'($urandom_range(0, 255));
    load_all();
    run_img("retrig", 3, 200, -1);
    peek_check("retrig addr10", 10, img[10]);
    readback();

    for (int a = 0; a < NPIX; a++) img[a] = 16'($urandom);
    load_all();
    run_img("abort", 1, -1, 500);
    readback();
    peek_check("abort input kept", 40, img[40]);
    run_img("restart", 1, -1, -1);
    readback();
    peek_check("restart input kept", 40, img[40]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
